// File: rtl/clock_ce_pkg.sv
// Shared definitions for the clock-enable generator.
//   - lock_state_e : lock qualification states (wait for lock, count stable, run)
//   - default accumulator width and lock qualification length
//   - named (inc, modulus) rate pairs for a 48 MHz master clock
//   - cnt_width()  : counter width helper that never returns zero
package clock_ce_pkg;

  typedef enum logic [1:0] {
    StWait   = 2'd0,
    StStable = 2'd1,
    StRun    = 2'd2
  } lock_state_e;

  localparam int unsigned ACC_W_DEFAULT       = 16;
  localparam int unsigned LOCK_CYCLES_DEFAULT = 1024;

  // Rate pairs for a 48 MHz master: f_ce = 48 MHz * inc / modulus.
  localparam int unsigned CE_4M_INC = 1;
  localparam int unsigned CE_4M_MOD = 12;
  localparam int unsigned CE_6M_INC = 1;
  localparam int unsigned CE_6M_MOD = 8;
  localparam int unsigned CE_8M_INC = 1;
  localparam int unsigned CE_8M_MOD = 6;
  // 44.1 kHz needs a modulus of 160000, so ACC_W must be at least 18.
  localparam int unsigned CE_AUDIO_44K1_INC = 147;
  localparam int unsigned CE_AUDIO_44K1_MOD = 160000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_accum.sv
// Single-channel fractional clock-enable generator.
// A phase accumulator adds inc each step and wraps at modulus, emitting a one-cycle ce
// pulse on every wrap. The rate registers load at run entry and afterwards only on a wrap,
// so a rate change never truncates or stretches the period in progress.
// Ports:
//   clock, reset : master clock, asynchronous active-high reset
//   load         : run entry; latch inc/modulus from the ports
//   step         : advance the accumulator this cycle
//   clear        : leaving run; zero accumulator and ce
//   inc, modulus : requested rate (ce rate = f_clock * inc / modulus)
//   ce           : registered clock-enable pulse
module ce_accum
  import clock_ce_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [ACC_W-1:0] inc,
  input  logic [ACC_W-1:0] modulus,
  output logic             ce
);

  logic [ACC_W-1:0] inc_q, mod_q, acc_q;
  logic             ce_q;
  logic [ACC_W-1:0] eff_inc;
  logic [ACC_W:0]   sum;
  logic             wrap;
  logic [ACC_W-1:0] acc_wrapped;

  // Illegal settings (inc > modulus, or modulus == 0) behave as inc == modulus: ce every
  // cycle with the accumulator holding its value.
  always_comb begin
    eff_inc = inc_q;
    if ((mod_q == '0) || (inc_q > mod_q)) begin
      eff_inc = mod_q;
    end
  end

  // One extra bit so a modulus of 2^ACC_W-1 cannot overflow the sum.
  assign sum         = {1'b0, acc_q} + {1'b0, eff_inc};
  assign wrap        = (sum >= {1'b0, mod_q});
  // True difference is below 2^ACC_W, so the low bits are exact.
  assign acc_wrapped = sum[ACC_W-1:0] - mod_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inc_q <= '0;
      mod_q <= '0;
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      if (clear) begin
        acc_q <= '0;
        ce_q  <= 1'b0;
      end else if (step) begin
        ce_q  <= wrap;
        acc_q <= wrap ? acc_wrapped : sum[ACC_W-1:0];
        if (wrap) begin
          inc_q <= inc;
          mod_q <= modulus;
        end
      end else begin
        ce_q <= 1'b0;
      end
      if (load) begin
        inc_q <= inc;
        mod_q <= modulus;
      end
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clock_ce_gen.sv
// Clock-enable generator on the synthesised master clock.
// Synchronises the synthesiser lock flag, requires it to stay high for LOCK_CYCLES
// before starting, then runs CHANNELS independent fractional-rate enable generators and
// releases the downstream reset. Losing lock stops all enables and re-asserts rst_out.
// Ports:
//   clock   : master clock
//   reset   : asynchronous active-high reset
//   locked  : synthesiser lock status, asynchronous to clock
//   inc     : per-channel increment, channel k at [k*ACC_W +: ACC_W]
//   modulus : per-channel modulus, same packing
//   ce      : one-cycle clock-enable pulse per channel
//   running : high while the enables are active
//   rst_out : synchronous active-high reset for downstream logic
module clock_ce_gen
  import clock_ce_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ACC_W       = ACC_W_DEFAULT,
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      locked,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  input  logic [CHANNELS*ACC_W-1:0] modulus,
  output logic [CHANNELS-1:0]       ce,
  output logic                      running,
  output logic                      rst_out
);

  localparam int unsigned      CNT_W    = cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic        lk_meta_q, lk_s_q;
  lock_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        running_q, rst_out_q;
  logic        acc_load, acc_step, acc_clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StWait;
      cnt_q     <= '0;
      running_q <= 1'b0;
      rst_out_q <= 1'b1;
    end else begin
      unique case (state_q)
        StWait: begin
          cnt_q <= '0;
          if (lk_s_q) begin
            state_q <= StStable;
          end
        end
        StStable: begin
          if (!lk_s_q) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= StRun;
            running_q <= 1'b1;
            rst_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!lk_s_q) begin
            state_q   <= StWait;
            cnt_q     <= '0;
            running_q <= 1'b0;
            rst_out_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StWait;
          cnt_q     <= '0;
          running_q <= 1'b0;
          rst_out_q <= 1'b1;
        end
      endcase
    end
  end

  // Rate registers load on the same edge that enters run, so they are valid for the
  // first accumulation.
  assign acc_load  = (state_q == StStable) && lk_s_q && (cnt_q == CNT_LAST);
  assign acc_step  = (state_q == StRun) && lk_s_q;
  assign acc_clear = (state_q == StRun) && !lk_s_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    ce_accum #(
      .ACC_W(ACC_W)
    ) u_accum (
      .clock  (clock),
      .reset  (reset),
      .load   (acc_load),
      .step   (acc_step),
      .clear  (acc_clear),
      .inc    (inc[k*ACC_W +: ACC_W]),
      .modulus(modulus[k*ACC_W +: ACC_W]),
      .ce     (ce[k])
    );
  end

  assign running = running_q;
  assign rst_out = rst_out_q;

endmodule

// File: tb/tb_clock_ce_gen.sv
module tb_clock_ce_gen;

  localparam int unsigned CHANNELS    = 4;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam int          LAT_MIN     = 2 + LOCK_CYCLES;
  localparam int          LAT_MAX     = 3 + LOCK_CYCLES;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      locked;
  logic [CHANNELS*ACC_W-1:0] inc;
  logic [CHANNELS*ACC_W-1:0] modulus;
  logic [CHANNELS-1:0]       ce;
  logic                      running;
  logic                      rst_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clock_ce_gen #(
    .CHANNELS   (CHANNELS),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .inc    (inc),
    .modulus(modulus),
    .ce     (ce),
    .running(running),
    .rst_out(rst_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rate(input int ch, input int unsigned i, input int unsigned m);
    inc[ch*ACC_W +: ACC_W]     = ACC_W'(i);
    modulus[ch*ACC_W +: ACC_W] = ACC_W'(m);
  endtask

  // Ticks until ce[ch] is seen; n = tick index (1-based) or -1 on timeout.
  task automatic wait_pulse(input int ch, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (ce[ch] === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Edge index (0 = first edge after locked rose) at which rst_out is seen low.
  task automatic wait_run(input int limit, output int n, output bit early);
    n     = -1;
    early = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (ce !== '0) early = 1'b1;
      if (rst_out === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset  = 1'b1;
    locked = 1'b0;
    set_rate(0, 1, 12);
    set_rate(1, 24, 25);
    set_rate(2, 7, 7);
    set_rate(3, 9, 5);
    #2;
    checks++;
    if (ce !== '0) begin
      errors++;
      $display("FAIL reset_ce: got %b, required 0", ce);
    end
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL reset_running: got %b, required 0", running);
    end
    checks++;
    if (rst_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_rst_out: got %b, required 1", rst_out);
    end
    repeat (3) tick();
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      tick();
      if (rst_out !== 1'b1 || running !== 1'b0 || ce !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_unlocked: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_lock_qualify();
    int  n, p;
    bit  early;
    locked = 1'b1;
    wait_run(60, n, early);
    checks++;
    if (n < LAT_MIN || n > LAT_MAX) begin
      errors++;
      $display("FAIL lock_latency: rst_out fell at edge %0d, required %0d..%0d", n, LAT_MIN,
               LAT_MAX);
    end
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL lock_running: got %b, required 1", running);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL lock_early_ce: got ce before run, required none");
    end
    wait_pulse(0, 30, p);
    checks++;
    if (p != 12) begin
      errors++;
      $display("FAIL lock_first_ce0: first pulse after %0d cycles, required 12", p);
    end
  endtask

  task automatic test_integer_rate();
    int cnt, last, badgap;
    cnt = 0;
    last = 0;
    badgap = 0;
    for (int i = 1; i <= 1200; i++) begin
      tick();
      if (ce[0] === 1'b1) begin
        if (i - last != 12) badgap++;
        last = i;
        cnt++;
      end
    end
    checks++;
    if (cnt != 100) begin
      errors++;
      $display("FAIL int_rate_count: got %0d pulses, required 100", cnt);
    end
    checks++;
    if (badgap != 0) begin
      errors++;
      $display("FAIL int_rate_gap: %0d gaps not 12, required 0", badgap);
    end
  endtask

  task automatic test_fractional_rate();
    int cnt, last, badgap;
    cnt = 0;
    last = -1;
    badgap = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (ce[1] === 1'b1) begin
        if (last >= 0 && (i - last) > 2) badgap++;
        last = i;
        cnt++;
      end
    end
    checks++;
    if (cnt != 2400) begin
      errors++;
      $display("FAIL frac_rate_count: got %0d pulses, required 2400", cnt);
    end
    checks++;
    if (badgap != 0) begin
      errors++;
      $display("FAIL frac_rate_gap: %0d gaps over 2, required 0", badgap);
    end
  endtask

  task automatic test_edge_rates();
    int bad2, bad3;
    bad2 = 0;
    bad3 = 0;
    repeat (50) begin
      tick();
      if (ce[2] !== 1'b1) bad2++;
      if (ce[3] !== 1'b1) bad3++;
    end
    checks++;
    if (bad2 != 0) begin
      errors++;
      $display("FAIL edge_inc_eq_mod: %0d low cycles, required 0", bad2);
    end
    checks++;
    if (bad3 != 0) begin
      errors++;
      $display("FAIL edge_illegal_clamp: %0d non-high cycles, required 0", bad3);
    end
  endtask

  task automatic test_rate_switch();
    int p, g;
    wait_pulse(0, 30, p);
    checks++;
    if (p < 1) begin
      errors++;
      $display("FAIL switch_sync: no pulse in 30 cycles, required one");
    end
    repeat (5) tick();
    set_rate(0, 1, 6);
    wait_pulse(0, 30, g);
    checks++;
    if (g + 5 != 12) begin
      errors++;
      $display("FAIL switch_gap0: got %0d, required 12", g + 5);
    end
    wait_pulse(0, 30, g);
    checks++;
    if (g != 6) begin
      errors++;
      $display("FAIL switch_gap1: got %0d, required 6", g);
    end
    wait_pulse(0, 30, g);
    checks++;
    if (g != 6) begin
      errors++;
      $display("FAIL switch_gap2: got %0d, required 6", g);
    end
  endtask

  // 65534/65535: after the single skipped cycle, ~65534 consecutive pulses follow.
  task automatic test_max_modulus();
    int cnt;
    set_rate(1, 65534, 65535);
    repeat (60) tick();
    cnt = 0;
    repeat (100) begin
      tick();
      if (ce[1] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 100) begin
      errors++;
      $display("FAIL max_modulus: got %0d pulses in 100, required 100", cnt);
    end
  endtask

  task automatic test_lock_loss();
    int n, p;
    bit early;
    set_rate(0, 1, 12);
    locked = 1'b0;
    repeat (3) tick();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL loss_running: got %b, required 0", running);
    end
    checks++;
    if (rst_out !== 1'b1) begin
      errors++;
      $display("FAIL loss_rst_out: got %b, required 1", rst_out);
    end
    checks++;
    if (ce !== '0) begin
      errors++;
      $display("FAIL loss_ce: got %b, required 0", ce);
    end
    locked = 1'b1;
    wait_run(60, n, early);
    checks++;
    if (n < LAT_MIN || n > LAT_MAX || early) begin
      errors++;
      $display("FAIL relock_latency: edge %0d early_ce %0d, required %0d..%0d and 0", n, early,
               LAT_MIN, LAT_MAX);
    end
    wait_pulse(0, 30, p);
    checks++;
    if (p != 12) begin
      errors++;
      $display("FAIL relock_acc_restart: first pulse after %0d, required 12", p);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ce !== '0) begin
      errors++;
      $display("FAIL async_reset_ce: got %b, required 0", ce);
    end
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_running: got %b, required 0", running);
    end
    checks++;
    if (rst_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_rst_out: got %b, required 1", rst_out);
    end
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_qualify();
    test_integer_rate();
    test_fractional_rate();
    test_edge_rates();
    test_rate_switch();
    test_max_modulus();
    test_lock_loss();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
